lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Load/store unit sitting directly upstream of the physical-memory block in the NPC core. It accepts one memory op per handshake from EXU and drives the PMEM request port (valid/raddr/wen/waddr/wdata/8-bit wmask). It captures the 1-cycle-latency read data, applies byte-lane extraction and sign/zero extension, and returns the result to WBU through a valid/ready handshake. Misaligned or illegal ops are flagged without touching memory.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; other values unsupported)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  EXU has a memory op
req_ready  out  1  LSU can accept (IDLE only)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_is_store  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1
resp_valid  out  1  result ready
resp_ready  in  1  WBU accepts result
resp_data  out  32  extended load data (0 for stores/errors)
resp_err  out  1  misaligned or illegal size
mem_valid  out  1  PMEM request
mem_raddr  out  32  word-aligned read address
mem_wen  out  1  PMEM write enable
mem_waddr  out  32  word-aligned write address
mem_wdata  out  32  lane-shifted store data
mem_wmask  out  8  byte mask; bits [7:4] always 0
mem_rdata  in  32  PMEM data, valid the cycle after mem_valid
load_cnt  out  32  completed loads (see Optional Feature)
store_cnt  out  32  completed stores (see Optional Feature)

Behaviour:
- Reset (async): state=IDLE; resp_valid=0, resp_err=0, resp_data=0, mem_valid=0, mem_wen=0, addr/data/mask regs=0, counters=0. req_ready=0 while rst high.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid: latch addr, size, unsigned, is_store, wdata. Err = size==11, or (half and addr[0]), or (word and addr[1:0]!=0). If err -> RESP with resp_err=1, resp_data=0, no mem access; else -> ISSUE.
- ISSUE (exactly one cycle): mem_valid=1; mem_raddr=mem_waddr={addr[31:2],2'b00}. Store: mem_wen=1, mem_wdata=wdata<<(8*addr[1:0]), mem_wmask byte=0001<<addr[1:0], half=0011<<addr[1:0], word=1111; next RESP. Load: mem_wen=0, mem_wmask=0; next CAPTURE.
- CAPTURE: sample mem_rdata; shift right by 8*addr[1:0]; byte/half sign-extend unless unsigned; word passes through; register into resp_data; next RESP.
- RESP: resp_valid=1, resp_data/resp_err stable until resp_valid&&resp_ready, then -> IDLE (no same-cycle new accept; req_ready rises next cycle).
- mem_valid/mem_wen are 0 outside ISSUE; no PMEM access is ever issued for an erroring op.
- Latency: accept edge at cycle 0; load resp_valid in cycle 3, store in cycle 2, error in cycle 1. Throughput: at most one op in flight.
- Reset mid-operation: abandon op, outputs to reset values immediately; a store whose ISSUE cycle was not completed is not written.

Optional Feature:
LSU_PERF_EN. Defined: load_cnt/store_cnt increment (wrapping at 2^32) on each non-error load/store response handshake; errors not counted. Undefined: both ports tied to 0, no counter flops.

Test Plan:
- mem word 0x80000004=0x8899AABB; load byte signed addr 0x80000005 -> mem_raddr=0x80000004, resp_data=0xFFFFFFAA in cycle 3, resp_err=0.
- Same word, load half unsigned addr 0x80000006 -> resp_data=0x00008899; half signed -> 0xFFFF8899.
- Store byte 0x12345678 to 0x80000003 -> single ISSUE cycle with mem_wen=1, mem_waddr=0x80000000, mem_wdata=0x78000000, mem_wmask=0x08; resp_valid in cycle 2.
- Load word at 0x80000002 and req_size=11 -> resp_err=1, resp_data=0, mem_valid never asserted.
- Hold resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0; release -> IDLE next cycle.
- Assert rst during CAPTURE -> resp_valid=0, mem_valid=0 immediately; with LSU_PERF_EN, after 3 loads + 2 stores + 1 error: load_cnt=3, store_cnt=2.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between EXU/WBU and the physical-memory port.
// Accepts one memory op at a time, issues a single PMEM request, captures
// the 1-cycle-latency read data, lane-extracts and extends it, and returns
// the result over a valid/ready handshake. Misaligned or illegal-size ops
// skip memory entirely and respond with resp_err.
// Optional build macro: LSU_PERF_EN enables the load/store completion counters.
`timescale 1ns/1ps

module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       load_cnt,
  output logic [31:0]       store_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              store_q;
  logic              req_err;
  logic [3:0]        lane_mask;
  logic [DATA_W-1:0] rdata_shifted;
  logic [DATA_W-1:0] load_ext;

  // Both PMEM ports share the word-aligned address of the op in flight
  assign mem_raddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_waddr = {addr_q[ADDR_W-1:2], 2'b00};

  // Classify an incoming request as illegal size or misaligned
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)
      req_err = 1'b1;
    else if (req_size == 2'b01 && req_addr[0])
      req_err = 1'b1;
    else if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  // Byte-lane enables for the latched store, before widening to the 8-bit port
  always_comb begin
    lane_mask = 4'b0000;
    case (size_q)
      2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
      2'b01:   lane_mask = 4'b0011 << addr_q[1:0];
      default: lane_mask = 4'b1111;
    endcase
  end

  // Move the addressed lane down to bit 0 and sign/zero extend it
  always_comb begin
    rdata_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext      = mem_rdata;
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'b0, rdata_shifted[7:0]}
                                     : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_ext = unsigned_q ? {16'b0, rdata_shifted[15:0]}
                                     : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic and handshake / PMEM strobes, all decoded from state
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_wdata  = '0;
    mem_wmask  = 8'h00;
    case (state)
      S_IDLE: begin
        req_ready = ~rst;
        if (req_valid)
          next_state = req_err ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        if (store_q) begin
          mem_wen    = 1'b1;
          mem_wdata  = wdata_q << {addr_q[1:0], 3'b000};
          mem_wmask  = {4'b0000, lane_mask};
          next_state = S_RESP;
        end else begin
          next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Latch the op on accept and build the response payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      store_q    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else if (state == S_IDLE && req_valid) begin
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      store_q    <= req_is_store;
      resp_data  <= '0;
      resp_err   <= req_err;
    end else if (state == S_CAPTURE) begin
      resp_data  <= load_ext;
    end
  end

`ifdef LSU_PERF_EN
  // Count completed non-error loads and stores at the response handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= 32'd0;
      store_cnt <= 32'd0;
    end else if (state == S_RESP && resp_ready && !resp_err) begin
      if (store_q)
        store_cnt <= store_cnt + 32'd1;
      else
        load_cnt  <= load_cnt + 32'd1;
    end
  end
`else
  assign load_cnt  = 32'd0;
  assign store_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl.
// A word-wide PMEM emulator answers the DUT; a separate byte-addressed
// reference memory predicts every response, lane mask and counter value.
`timescale 1ns/1ps

module tb_lsu_ctrl;

  localparam bit PERF =
`ifdef LSU_PERF_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_valid;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  int total;
  int bad;
  int load_cnt_m;
  int store_cnt_m;

  logic [31:0] pmem    [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];

  lsu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_is_store (req_is_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .mem_valid    (mem_valid),
    .mem_raddr    (mem_raddr),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rdata    (mem_rdata),
    .load_cnt     (load_cnt),
    .store_cnt    (store_cnt)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of never-written memory, derived from the word address
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] pmem_read(input logic [31:0] a);
    if (pmem.exists(a))
      return pmem[a];
    return init_word(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a))
      return ref_mem[a];
    w = init_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  // PMEM emulator: masked writes, read data returned one cycle after the request
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_valid) begin
      w = pmem_read(mem_waddr);
      if (mem_wen) begin
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i])
            w[8*i +: 8] = mem_wdata[8*i +: 8];
        pmem[mem_waddr] = w;
      end
      mem_rdata <= pmem_read(mem_raddr);
    end
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    pmem[a] = w;
    for (int i = 0; i < 4; i++)
      ref_mem[a + 32'(i)] = w[8*i +: 8];
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_load_cnt"},  load_cnt,  PERF ? 32'(load_cnt_m)  : 32'd0);
    checkOutput({tag, "_store_cnt"}, store_cnt, PERF ? 32'(store_cnt_m) : 32'd0);
  endtask

  task automatic doReset();
    rst          = 1'b1;
    req_valid    = 1'b0;
    resp_ready   = 1'b0;
    load_cnt_m   = 0;
    store_cnt_m  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Run one op end to end and check it against the reference model
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic st,
                               input logic [1:0] sz, input logic un, input int hold,
                               output logic [31:0] got_data);
    logic        err;
    int          nbytes;
    int          off;
    int          exp_lat;
    int          lat;
    int          mv_cnt;
    logic [31:0] exp_data;
    logic [31:0] exp_wdata;
    logic [7:0]  exp_mask;
    logic [31:0] held_data;

    err     = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    nbytes  = 1 << sz;
    off     = int'(a[1:0]);
    exp_lat = err ? 1 : (st ? 2 : 3);
    exp_data = 32'd0;
    if (!err && !st) begin
      for (int i = 0; i < nbytes; i++)
        exp_data = exp_data | (32'(ref_byte(a + 32'(i))) << (8 * i));
      if (!un && nbytes < 4 && exp_data[8*nbytes-1])
        exp_data = exp_data | (32'hFFFF_FFFF << (8 * nbytes));
    end
    exp_wdata = wd << (8 * off);
    exp_mask  = 8'(((1 << nbytes) - 1) << off);

    @(negedge clk);
    req_addr     = a;
    req_wdata    = wd;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_valid    = 1'b1;
    checkOutput("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat    = 0;
    mv_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_valid) begin
        mv_cnt++;
        checkOutput("mem_raddr", mem_raddr, {a[31:2], 2'b00});
        checkOutput("mem_wen", mem_wen, st);
        if (st) begin
          checkOutput("mem_waddr", mem_waddr, {a[31:2], 2'b00});
          checkOutput("mem_wdata", mem_wdata, exp_wdata);
          checkOutput("mem_wmask", mem_wmask, exp_mask);
        end else begin
          checkOutput("mem_wmask_load", mem_wmask, 8'h00);
        end
      end
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    checkOutput("latency", lat, exp_lat);
    checkOutput("mem_access_cnt", mv_cnt, err ? 0 : 1);
    got_data = resp_data;
    if (lat == 0) begin
      doReset();
      return;
    end
    checkOutput("resp_err", resp_err, err);
    checkOutput("resp_data", resp_data, exp_data);
    checkOutput("req_ready_busy", req_ready, 1'b0);

    held_data = resp_data;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", resp_valid, 1'b1);
      checkOutput("hold_data", resp_data, held_data);
      checkOutput("hold_err", resp_err, err);
      checkOutput("hold_req_ready", req_ready, 1'b0);
      checkOutput("hold_mem_valid", mem_valid, 1'b0);
    end

    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    if (!err) begin
      if (st) begin
        for (int i = 0; i < nbytes; i++)
          ref_mem[a + 32'(i)] = wd[8*i +: 8];
        store_cnt_m++;
      end else begin
        load_cnt_m++;
      end
    end
    @(negedge clk);
    checkOutput("post_resp_valid", resp_valid, 1'b0);
    checkOutput("post_req_ready", req_ready, 1'b1);
    checkCounters("post");
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] ra;
    logic [1:0]  rs;

    total        = 0;
    bad          = 0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    req_is_store = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;

    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    load_cnt_m = 0;
    store_cnt_m = 0;
    #2;
    checkOutput("rst_req_ready", req_ready, 1'b0);
    checkOutput("rst_resp_valid", resp_valid, 1'b0);
    checkOutput("rst_mem_valid", mem_valid, 1'b0);
    checkOutput("rst_mem_wen", mem_wen, 1'b0);
    checkOutput("rst_resp_data", resp_data, 32'd0);
    checkOutput("rst_resp_err", resp_err, 1'b0);
    checkCounters("rst");
    doReset();

    $display("[TB] directed loads and stores");
    preload(32'h8000_0004, 32'h8899_AABB);
    applyStimulus(32'h8000_0005, 32'd0, 1'b0, 2'b00, 1'b0, 0, d);
    checkOutput("lb_signed", d, 32'hFFFF_FFAA);
    applyStimulus(32'h8000_0006, 32'd0, 1'b0, 2'b01, 1'b1, 0, d);
    checkOutput("lhu", d, 32'h0000_8899);
    applyStimulus(32'h8000_0006, 32'd0, 1'b0, 2'b01, 1'b0, 0, d);
    checkOutput("lh_signed", d, 32'hFFFF_8899);
    applyStimulus(32'h8000_0003, 32'h1234_5678, 1'b1, 2'b00, 1'b0, 0, d);
    checkOutput("sb_pmem", pmem_read(32'h8000_0000) & 32'hFF00_0000, 32'h7800_0000);
    applyStimulus(32'h8000_0002, 32'd0, 1'b0, 2'b10, 1'b0, 0, d);
    applyStimulus(32'h8000_0000, 32'd0, 1'b0, 2'b11, 1'b0, 0, d);
    applyStimulus(32'h8000_0004, 32'd0, 1'b0, 2'b10, 1'b0, 5, d);
    checkOutput("lw_held", d, 32'h8899_AABB);

    $display("[TB] reset during capture");
    @(negedge clk);
    req_addr = 32'h8000_0004; req_size = 2'b10; req_is_store = 1'b0; req_unsigned = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_resp_valid", resp_valid, 1'b0);
    checkOutput("midrst_mem_valid", mem_valid, 1'b0);
    checkOutput("midrst_req_ready", req_ready, 1'b0);
    checkOutput("midrst_resp_data", resp_data, 32'd0);
    doReset();

    $display("[TB] reset during store issue");
    @(negedge clk);
    req_addr = 32'h8000_0010; req_wdata = 32'hDEAD_BEEF; req_size = 2'b10; req_is_store = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("issue_rst_mem_valid", mem_valid, 1'b0);
    checkOutput("issue_rst_mem_wen", mem_wen, 1'b0);
    doReset();
    applyStimulus(32'h8000_0010, 32'd0, 1'b0, 2'b10, 1'b0, 0, d);
    checkOutput("aborted_store", d, init_word(32'h8000_0010));

    $display("[TB] counter sequence");
    doReset();
    applyStimulus(32'h8000_0020, 32'hCAFE_F00D, 1'b1, 2'b10, 1'b0, 0, d);
    applyStimulus(32'h8000_0021, 32'd0, 1'b0, 2'b00, 1'b1, 1, d);
    applyStimulus(32'h8000_0023, 32'd0, 1'b0, 2'b01, 1'b0, 0, d);
    applyStimulus(32'h8000_0022, 32'h0000_BEEF, 1'b1, 2'b01, 1'b0, 2, d);
    applyStimulus(32'h8000_0020, 32'd0, 1'b0, 2'b10, 1'b0, 0, d);
    applyStimulus(32'h8000_0024, 32'd0, 1'b0, 2'b01, 1'b1, 0, d);
    checkOutput("seq_load_cnt", load_cnt, PERF ? 32'd3 : 32'd0);
    checkOutput("seq_store_cnt", store_cnt, PERF ? 32'd2 : 32'd0);

    $display("[TB] randomized ops");
    for (int n = 0; n < 120; n++) begin
      ra = 32'h8000_0000 + 32'($urandom_range(0, 47));
      rs = 2'($urandom_range(0, 3));
      applyStimulus(ra, $urandom, 1'($urandom_range(0, 1)), rs,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
